// File: rtl/mage_stream_in_aligner.sv
// mage_stream_in_aligner: per-channel first-word-fall-through FIFOs that release one aligned
// PEA input vector only when every channel referenced by an enabled DIN holds data.
//
// state  | meaning
// IDLE   | no DIN enabled; FIFOs still accept data, no vectors are issued
// STREAM | a vector is issued whenever all referenced FIFOs are non-empty
// FLUSH  | single cycle; pointers and beat counter cleared, no handshakes
module mage_stream_in_aligner #(
    parameter int N_CH       = 4,
    parameter int N_DIN      = 4,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int LOG_N_CH  = (N_CH == 1) ? 1 : $clog2(N_CH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cfg_we_i,
    input  logic [N_DIN*LOG_N_CH-1:0] cfg_sel_i,
    input  logic [N_DIN-1:0]          cfg_en_i,
    input  logic                      flush_i,
    input  logic [N_CH*DW-1:0]        dma_data_i,
    input  logic [N_CH-1:0]           dma_valid_i,
    output logic [N_CH-1:0]           dma_ready_o,
    output logic [N_DIN*DW-1:0]       pea_data_o,
    output logic                      pea_valid_o,
    input  logic                      pea_ready_i,
    output logic [15:0]               beat_cnt_o,
    output logic                      busy_o
);

    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned N_CH_U = N_CH;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [LOG_N_CH-1:0] sel [N_DIN];
    logic [N_DIN-1:0]    en;
    logic [N_DIN-1:0]    en_eff;
    logic [N_CH-1:0]     referenced;
    logic [N_CH-1:0]     empty;
    logic [N_CH-1:0]     full;
    logic [N_CH-1:0]     push;
    logic [N_CH-1:0]     pop;
    logic [AW:0]         wr_ptr [N_CH];
    logic [AW:0]         rd_ptr [N_CH];
    logic [DW-1:0]       mem    [N_CH][FIFO_DEPTH];
    logic [DW-1:0]       head   [N_CH];
    logic                accepting;
    logic                handshake;
    logic [15:0]         beat_cnt;

    // A DIN pointing at a non-existent channel behaves as disabled.
    always_comb begin
        for (int d = 0; d < N_DIN; d++) begin
            en_eff[d] = en[d] && (32'(sel[d]) < N_CH_U);
        end
    end

    always_comb begin
        referenced = '0;
        for (int d = 0; d < N_DIN; d++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (en_eff[d] && (sel[d] == LOG_N_CH'(c))) begin
                    referenced[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            empty[c] = (wr_ptr[c] == rd_ptr[c]);
            full[c]  = (wr_ptr[c][AW] != rd_ptr[c][AW]) &&
                       (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
            head[c]  = mem[c][rd_ptr[c][AW-1:0]];
        end
    end

    // Ready depends only on fullness, never on a same-cycle pop.
    assign accepting   = !rst_i && (state != ST_FLUSH);
    assign dma_ready_o = {N_CH{accepting}} & ~full;
    assign push        = dma_valid_i & dma_ready_o;

    assign pea_valid_o = !rst_i && (state == ST_STREAM) && (|referenced) &&
                         ((referenced & empty) == '0);
    assign handshake   = pea_valid_o && pea_ready_i;
    assign pop         = {N_CH{handshake}} & referenced;

    always_comb begin
        pea_data_o = '0;
        for (int d = 0; d < N_DIN; d++) begin
            if (en_eff[d]) begin
                pea_data_o[d*DW +: DW] = head[sel[d]];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = ST_FLUSH;
        end else begin
            case (state)
                ST_IDLE:   if (en != '0) state_nxt = ST_STREAM;
                ST_STREAM: if (en == '0) state_nxt = ST_IDLE;
                ST_FLUSH:  state_nxt = (en != '0) ? ST_STREAM : ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Configuration loads even alongside flush_i, so both land in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int d = 0; d < N_DIN; d++) begin
                sel[d] <= LOG_N_CH'(d % N_CH);
            end
            en <= '1;
        end else if (cfg_we_i) begin
            for (int d = 0; d < N_DIN; d++) begin
                sel[d] <= cfg_sel_i[d*LOG_N_CH +: LOG_N_CH];
            end
            en <= cfg_en_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || (state == ST_FLUSH)) begin
            for (int c = 0; c < N_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + (AW+1)'(1);
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < N_CH; c++) begin
            if (push[c]) begin
                mem[c][wr_ptr[c][AW-1:0]] <= dma_data_i[c*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || (state == ST_FLUSH)) begin
            beat_cnt <= '0;
        end else if (handshake) begin
            beat_cnt <= beat_cnt + 16'd1;
        end
    end

    assign beat_cnt_o = beat_cnt;
    assign busy_o     = !(&empty) || (state == ST_FLUSH);

endmodule

// File: doc/mage_stream_in_aligner.md
MAGE_STREAM_IN_ALIGNER -- requirements
Module: mage_stream_in_aligner

Interface
REQ-001 SHALL have parameter N_CH, default 4: DMA channels grouped in one input stream.
REQ-002 SHALL have parameter N_DIN, default 4: PEA data inputs fed by the stream.
REQ-003 SHALL have parameter DW, default 32: data width per channel.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: per-channel FIFO depth, power of 2, at least 2.
REQ-005 SHALL derive LOG_N_CH = 1 if N_CH==1, else clog2(N_CH).
REQ-006 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port cfg_we_i, input, 1: load cfg_sel_i and cfg_en_i.
REQ-009 SHALL have port cfg_sel_i, input, N_DIN*LOG_N_CH: per-DIN source channel index.
REQ-010 SHALL have port cfg_en_i, input, N_DIN: per-DIN enable mask.
REQ-011 SHALL have port flush_i, input, 1: discard all buffered data.
REQ-012 SHALL have port dma_data_i, input, N_CH*DW: channel data.
REQ-013 SHALL have port dma_valid_i, input, N_CH: per-channel valid.
REQ-014 SHALL have port dma_ready_o, output, N_CH: per-channel ready.
REQ-015 SHALL have port pea_data_o, output, N_DIN*DW: aligned PEA input vector.
REQ-016 SHALL have port pea_valid_o, output, 1: whole vector valid.
REQ-017 SHALL have port pea_ready_i, input, 1: PEA accepts the vector.
REQ-018 SHALL have port beat_cnt_o, output, 16: count of accepted vectors.
REQ-019 SHALL have port busy_o, output, 1: any FIFO non-empty or state is FLUSH.

Function
REQ-020 SHALL keep one first-word-fall-through FIFO of FIFO_DEPTH x DW per channel; a push occurs when dma_valid_i[c] and dma_ready_o[c] are both high.
REQ-021 SHALL drive dma_ready_o[c] = !full[c] in state STREAM or IDLE, and 0 in FLUSH and while rst_i is high; a full FIFO SHALL NOT accept data even in a cycle in which it is popped (no pass-through).
REQ-022 SHALL treat channel c as "referenced" when some enabled DIN d has sel[d]==c.
REQ-023 SHALL assert pea_valid_o only in STREAM, and only when every referenced channel's FIFO is non-empty.
REQ-024 SHALL drive pea_data_o[d] = head of FIFO sel[d] if en[d] is set, else 0; when one channel is referenced by several DINs, its head SHALL be broadcast to each of them.
REQ-025 SHALL, on pea_valid_o && pea_ready_i, pop each referenced FIFO exactly once and increment beat_cnt_o (mod 2^16).
REQ-026 SHALL never pop unreferenced FIFOs; they fill and backpressure their channel.
REQ-027 SHALL make data pushed into an empty FIFO visible at pea_valid_o no earlier than the following cycle (1-cycle minimum latency).
REQ-028 SHALL allow a simultaneous push and pop on a non-full FIFO, leaving its occupancy unchanged.
REQ-029 SHALL implement FSM states IDLE, STREAM and FLUSH.
REQ-030 SHALL transition IDLE->STREAM when en != 0, and STREAM->IDLE when en == 0.
REQ-031 SHALL transition any state->FLUSH on flush_i; FLUSH SHALL last exactly 1 cycle, then go to STREAM if en != 0, else IDLE.
REQ-032 SHALL, in FLUSH, reset all FIFO pointers, empty all FIFOs and clear beat_cnt_o to 0; flush_i held high SHALL keep the FSM in FLUSH.
REQ-033 SHALL register configuration on cfg_we_i, effective next cycle; a handshake in the same cycle as cfg_we_i SHALL pop according to the old configuration.
REQ-034 SHALL give flush_i priority over cfg_we_i; both SHALL take effect in the same cycle.
REQ-035 SHALL ignore cfg_sel_i entries >= N_CH by treating that DIN as disabled.

Reset
REQ-036 SHALL, with rst_i high at a clock edge: empty all FIFOs, set state IDLE, sel[d] = d mod N_CH, en = all ones, beat_cnt_o = 0, pea_valid_o = 0, dma_ready_o = 0, busy_o = 0.
REQ-037 SHALL enter STREAM on the first cycle after reset (en != 0), with dma_ready_o all ones.
REQ-038 SHALL discard in-flight data and perform no handshakes when reset is asserted mid-stream.

Verification
REQ-039 SHALL pass default-config passthrough: push 0x11/0x22/0x33/0x44 on channels 0-3 in one cycle -> next cycle pea_valid_o=1, pea_data_o={0x44,0x33,0x22,0x11}; beat_cnt_o=1 after pea_ready_i.
REQ-040 SHALL pass skew alignment: channel 2 pushes 3 cycles after the others -> pea_valid_o stays 0 until the cycle after channel 2's push, and data remains aligned.
REQ-041 SHALL pass broadcast: sel={0,0,0,0}, en=0xF, push 0xA5 on channel 0 -> all four DINs show 0xA5, one pop, channels 1-3 fill to FIFO_DEPTH then dma_ready_o[3:1]=0.
REQ-042 SHALL pass backpressure: pea_ready_i=0 for 6 cycles with continuous input -> FIFOs reach 4 entries, dma_ready_o=0, no data lost or reordered after release.
REQ-043 SHALL pass flush: flush_i pulsed with 3 entries buffered -> one cycle with dma_ready_o=0 and pea_valid_o=0, then busy_o=0, beat_cnt_o=0 and FIFOs empty.
REQ-044 SHALL pass mid-stream reconfig: cfg_we_i with en=0 during a handshake -> that beat completes, then IDLE with pea_valid_o=0.
